// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Initiator side of the word-wide data memory port. Accepts
//                byte/half/word loads and stores from the CPU datapath and
//                drives the memory's addr/wdata/write port. Memory reads are
//                combinational and writes happen on the clock edge. Sub-word
//                stores are read-modify-write. Loads are lane-extracted and
//                then sign- or zero-extended.
//  Ports       : clock      - system clock, rising edge
//                reset      - asynchronous, active-low reset
//                req        - access request, sampled only while ready=1
//                we         - 1 = store, 0 = load
//                size       - 00 byte, 01 half, 10 word, 11 illegal
//                sign       - loads: 1 sign-extend, 0 zero-extend
//                addr       - byte address
//                wdata      - store data, right-justified
//                ready      - high only in IDLE
//                done       - one-cycle completion pulse (also on error)
//                err        - one-cycle pulse with done on a bad access
//                rdata      - load result, held until the next load completes
//                mem_addr   - word-aligned memory address
//                mem_wdata  - full word written to memory
//                mem_write  - memory write enable, one cycle per store
//                mem_rdata  - memory read data, combinational from mem_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t      r_state;
    state_t      w_next_state;

    // Request fields captured at acceptance
    logic        r_we;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [1:0]  r_bidx;        // byte lane, endianness already applied
    logic        r_hidx;        // half lane, endianness already applied
    logic [15:0] r_wdata;       // only the sub-word part is needed after accept

    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_word_store;
    logic [1:0]  w_bidx;
    logic        w_hidx;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept     = req && (r_state == ST_IDLE);
    assign w_misaligned = (size == 2'b11)
                       || ((size == c_SIZE_HALF) && addr[0])
                       || ((size == c_SIZE_WORD) && (addr[1:0] != 2'b00));
    assign w_word_store = we && (size == c_SIZE_WORD);

    // Big-endian mode mirrors the lane index within the word
    assign w_bidx = LITTLE_ENDIAN ? addr[1:0] : ~addr[1:0];
    assign w_hidx = LITTLE_ENDIAN ? addr[1]   : ~addr[1];

    // ------------------------------------------------------------------
    // Lane extraction and extension for loads
    // ------------------------------------------------------------------
    always_comb begin
        w_lbyte = mem_rdata[7:0];
        case (r_bidx)
            2'd0:    w_lbyte = mem_rdata[7:0];
            2'd1:    w_lbyte = mem_rdata[15:8];
            2'd2:    w_lbyte = mem_rdata[23:16];
            default: w_lbyte = mem_rdata[31:24];
        endcase
        w_lhalf = r_hidx ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        w_load_val = mem_rdata;
        case (r_size)
            c_SIZE_BYTE: w_load_val = {{24{r_sign & w_lbyte[7]}}, w_lbyte};
            c_SIZE_HALF: w_load_val = {{16{r_sign & w_lhalf[15]}}, w_lhalf};
            default:     w_load_val = mem_rdata;   // word load ignores sign
        endcase
    end

    // ------------------------------------------------------------------
    // Read-modify-write merge: replace only the addressed lane
    // ------------------------------------------------------------------
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == c_SIZE_BYTE) begin
            case (r_bidx)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_size == c_SIZE_HALF) begin
            if (r_hidx) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0]  = r_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        mem_write    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (w_misaligned) begin
                        w_next_state = ST_ERR;
                    end else if (w_word_store) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        // loads and sub-word stores both need the memory word
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_next_state = r_we ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                mem_write    = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_ERR: begin
                done         = 1'b1;
                err          = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_size      <= 2'b00;
            r_bidx      <= 2'b00;
            r_hidx      <= 1'b0;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rdata     <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_we       <= we;
                r_sign     <= sign;
                r_size     <= size;
                r_bidx     <= w_bidx;
                r_hidx     <= w_hidx;
                r_wdata    <= wdata[15:0];
                r_mem_addr <= {addr[31:2], 2'b00};
                // Word stores skip READ, so the write word must be ready now
                if (w_word_store && !w_misaligned) begin
                    r_mem_wdata <= wdata;
                end
            end
            if (r_state == ST_READ) begin
                if (r_we) begin
                    r_mem_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load_val;
                end
            end
        end
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A little-endian and
//                a big-endian instance receive identical stimulus, each with
//                its own word memory, and are checked against an arithmetic
//                reference model of loads, stores, errors and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_clr;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        rdy [2];
    logic        dn  [2];
    logic        er  [2];
    logic        mw  [2];
    logic [31:0] rd  [2];
    logic [31:0] ma  [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2];

    logic [31:0] mem     [2][64];
    logic [31:0] ref_mem [2][64];
    logic [31:0] ref_rdata [2];

    int          obs_done [2];
    int          obs_wcyc [2];
    int          obs_wcnt [2];
    logic        obs_err  [2];
    logic [31:0] obs_addr1 [2];
    logic [31:0] obs_rd   [2];

    int          n_cmp;
    int          n_fail;

    load_store_unit #(.LITTLE_ENDIAN(1'b1)) u_le (
        .clock(clk), .reset(rst_n), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .ready(rdy[0]), .done(dn[0]), .err(er[0]),
        .rdata(rd[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_write(mw[0]),
        .mem_rdata(mrd[0])
    );

    load_store_unit #(.LITTLE_ENDIAN(1'b0)) u_be (
        .clock(clk), .reset(rst_n), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .ready(rdy[1]), .done(dn[1]), .err(er[1]),
        .rdata(rd[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_write(mw[1]),
        .mem_rdata(mrd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memories: combinational read, clocked write
    assign mrd[0] = mem[0][ma[0][7:2]];
    assign mrd[1] = mem[1][ma[1][7:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_clr) begin
                for (int j = 0; j < 64; j++) mem[i][j] <= '0;
            end else if (mw[i]) begin
                mem[i][ma[i][7:2]] <= mwd[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    // Bit offset of the addressed lane inside the word
    function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a, input bit le);
        int k;
        if (sz == 2'd0) begin
            k = int'(a % 4);
            if (!le) k = 3 - k;
            return 8 * k;
        end
        if (sz == 2'd1) begin
            k = int'((a / 2) % 2);
            if (!le) k = 1 - k;
            return 16 * k;
        end
        return 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic model_op(input int i, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int e_done, output int e_wcyc, output logic e_err);
        logic [31:0] m;
        logic [31:0] word;
        logic [31:0] v;
        int          sh;
        int          idx;
        idx    = int'(a[7:2]);
        word   = ref_mem[i][idx];
        m      = lane_mask(sz);
        sh     = lane_shift(sz, a, i == 0);
        e_err  = is_bad(sz, a);
        e_wcyc = 0;
        if (e_err) begin
            e_done = 1;
        end else if (!w) begin
            e_done = 2;
            v = (word >> sh) & m;
            if (sg && sz != 2'd2 && (v & ((m >> 1) + 1)) != 0) v = v | ~m;
            ref_rdata[i] = v;
        end else if (sz == 2'd2) begin
            e_wcyc = 1;
            e_done = 2;
            ref_mem[i][idx] = wd;
        end else begin
            e_wcyc = 2;
            e_done = 3;
            ref_mem[i][idx] = (word & ~(m << sh)) | ((wd & m) << sh);
        end
    endtask

    // ------------------------------------------------------------------
    // Drive one access and record what both instances did, cycle by cycle
    // ------------------------------------------------------------------
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
        guard = 0;
        while (!(rdy[0] && rdy[1]) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b/%b required 1/1", rdy[0], rdy[1]);
        end
        @(posedge clk);
        #1;
        // Scramble inputs so only the captured request can matter
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            obs_done[i]  = 0;
            obs_wcyc[i]  = 0;
            obs_wcnt[i]  = 0;
            obs_err[i]   = 1'b0;
            obs_addr1[i] = ma[i];
            obs_rd[i]    = rd[i];
        end
        for (int c = 1; c <= 6; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (mw[i]) begin
                    obs_wcnt[i]++;
                    obs_wcyc[i] = c;
                end
                if (dn[i] && obs_done[i] == 0) begin
                    obs_done[i] = c;
                    obs_err[i]  = er[i];
                    obs_rd[i]   = rd[i];
                end
            end
            if (obs_done[0] != 0 && obs_done[1] != 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rdy[i], dn[i], er[i], mw[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_ctrl inst%0d: got rdy/done/err/wr=%b required 1000", i,
                         {rdy[i], dn[i], er[i], mw[i]});
            end
            n_cmp++;
            if (rd[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata inst%0d: got %h required 00000000", i, rd[i]);
            end
            n_cmp++;
            if (ma[i] !== 32'h0 || mwd[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mem_port inst%0d: got addr=%h wdata=%h required 0/0", i, ma[i], mwd[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
    endtask

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_le;   // little-endian result: memory word for stores, rdata otherwise
    } op_t;

    task automatic test_directed;
        op_t tbl [13];
        int  e_done;
        int  e_wcyc;
        logic e_err;
        logic [31:0] got;
        tbl = '{
            '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF},
            '{1'b0, 2'd2, 1'b1, 32'h08, 32'h0,        32'hDEADBEEF},
            '{1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, 32'h11223344},
            '{1'b1, 2'd0, 1'b0, 32'h06, 32'h000000AA, 32'h11AA3344},
            '{1'b1, 2'd1, 1'b0, 32'h04, 32'h0000BEEF, 32'h11AABEEF},
            '{1'b1, 2'd2, 1'b0, 32'h0C, 32'h80FF7F01, 32'h80FF7F01},
            '{1'b0, 2'd0, 1'b1, 32'h0E, 32'h0,        32'hFFFFFFFF},
            '{1'b0, 2'd0, 1'b0, 32'h0F, 32'h0,        32'h00000080},
            '{1'b0, 2'd1, 1'b1, 32'h0C, 32'h0,        32'h00007F01},
            '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        32'hFFFF80FF},
            '{1'b0, 2'd1, 1'b1, 32'h03, 32'h0,        32'hFFFF80FF},
            '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'hFFFF80FF},
            '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'hFFFF80FF}
        };
        for (int k = 0; k < 13; k++) begin
            access(tbl[k].w, tbl[k].sz, tbl[k].sg, tbl[k].a, tbl[k].wd);
            got = tbl[k].w ? mem[0][tbl[k].a[7:2]] : obs_rd[0];
            n_cmp++;
            if (got !== tbl[k].exp_le) begin
                n_fail++;
                $display("FAIL vector_le op%0d: got %h required %h", k, got, tbl[k].exp_le);
            end
            for (int i = 0; i < 2; i++) begin
                model_op(i, tbl[k].w, tbl[k].sz, tbl[k].sg, tbl[k].a, tbl[k].wd, e_done, e_wcyc, e_err);
                n_cmp++;
                if (obs_done[i] !== e_done || obs_err[i] !== e_err) begin
                    n_fail++;
                    $display("FAIL dir_done inst%0d op%0d: got cycle %0d err %b required cycle %0d err %b",
                             i, k, obs_done[i], obs_err[i], e_done, e_err);
                end
                n_cmp++;
                if (obs_wcyc[i] !== e_wcyc || obs_wcnt[i] !== ((e_wcyc != 0) ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL dir_write inst%0d op%0d: got cycle %0d count %0d required cycle %0d",
                             i, k, obs_wcyc[i], obs_wcnt[i], e_wcyc);
                end
                n_cmp++;
                if (obs_addr1[i] !== {tbl[k].a[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL dir_addr inst%0d op%0d: got %h required %h", i, k, obs_addr1[i],
                             {tbl[k].a[31:2], 2'b00});
                end
                n_cmp++;
                if (obs_rd[i] !== ref_rdata[i] || mem[i][tbl[k].a[7:2]] !== ref_mem[i][tbl[k].a[7:2]]) begin
                    n_fail++;
                    $display("FAIL dir_data inst%0d op%0d: got rdata %h mem %h required rdata %h mem %h",
                             i, k, obs_rd[i], mem[i][tbl[k].a[7:2]], ref_rdata[i], ref_mem[i][tbl[k].a[7:2]]);
                end
            end
        end
    endtask

    task automatic test_req_held;
        logic [31:0] vals [16];
        int   nd [2];
        int   nw [2];
        int   e_done;
        int   e_wcyc;
        logic e_err;
        for (int c = 0; c < 16; c++) vals[c] = $urandom;
        nd = '{0, 0};
        nw = '{0, 0};
        @(posedge clk);
        // Byte stores take four cycles, so with req held the unit should
        // accept at cycles 0, 4, 8 and 12 only
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'd0; sign = 1'b0; addr = 32'h0000_0031; wdata = vals[c];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (dn[i]) nd[i]++;
                if (mw[i]) nw[i]++;
            end
        end
        @(negedge clk);
        req = 1'b0;
        for (int c = 0; c < 16; c += 4) begin
            for (int i = 0; i < 2; i++) model_op(i, 1'b1, 2'd0, 1'b0, 32'h31, vals[c], e_done, e_wcyc, e_err);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (nd[i] !== 4 || nw[i] !== 4) begin
                n_fail++;
                $display("FAIL held_count inst%0d: got done=%0d writes=%0d required 4/4", i, nd[i], nw[i]);
            end
            n_cmp++;
            if (mem[i][12] !== ref_mem[i][12]) begin
                n_fail++;
                $display("FAIL held_data inst%0d: got %h required %h", i, mem[i][12], ref_mem[i][12]);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        @(posedge clk);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; sign = 1'b0; addr = 32'h0000_0025; wdata = 32'h0000_005A;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (mw[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_setup inst%0d: got mem_write=%b required 1", i, mw[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rdy[i], dn[i], er[i], mw[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL abort_ctrl inst%0d: got rdy/done/err/wr=%b required 1000", i,
                         {rdy[i], dn[i], er[i], mw[i]});
            end
            n_cmp++;
            if (rd[i] !== 32'h0 || ma[i] !== 32'h0 || mwd[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL abort_regs inst%0d: got rdata=%h addr=%h wdata=%h required zeros",
                         i, rd[i], ma[i], mwd[i]);
            end
            ref_rdata[i] = 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (mem[i][9] !== ref_mem[i][9]) begin
                n_fail++;
                $display("FAIL abort_mem inst%0d: got %h required %h", i, mem[i][9], ref_mem[i][9]);
            end
        end
    endtask

    task automatic test_random;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        int          e_done;
        int          e_wcyc;
        logic        e_err;
        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            a  = $urandom;
            wd = $urandom;
            // Bias toward legal alignment so most accesses reach memory
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            access(w, sz, sg, a, wd);
            for (int i = 0; i < 2; i++) begin
                model_op(i, w, sz, sg, a, wd, e_done, e_wcyc, e_err);
                n_cmp++;
                if (obs_done[i] !== e_done || obs_err[i] !== e_err) begin
                    n_fail++;
                    $display("FAIL rnd_done inst%0d op%0d: got cycle %0d err %b required cycle %0d err %b",
                             i, k, obs_done[i], obs_err[i], e_done, e_err);
                end
                n_cmp++;
                if (obs_wcyc[i] !== e_wcyc || obs_wcnt[i] !== ((e_wcyc != 0) ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL rnd_write inst%0d op%0d: got cycle %0d count %0d required cycle %0d",
                             i, k, obs_wcyc[i], obs_wcnt[i], e_wcyc);
                end
                n_cmp++;
                if (obs_addr1[i] !== {a[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL rnd_addr inst%0d op%0d: got %h required %h", i, k, obs_addr1[i], {a[31:2], 2'b00});
                end
                n_cmp++;
                if (obs_rd[i] !== ref_rdata[i] || mem[i][a[7:2]] !== ref_mem[i][a[7:2]]) begin
                    n_fail++;
                    $display("FAIL rnd_data inst%0d op%0d: got rdata %h mem %h required rdata %h mem %h",
                             i, k, obs_rd[i], mem[i][a[7:2]], ref_rdata[i], ref_mem[i][a[7:2]]);
                end
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        req     = 1'b0;
        we      = 1'b0;
        size    = 2'd0;
        sign    = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            ref_rdata[i] = 32'h0;
            for (int j = 0; j < 64; j++) ref_mem[i][j] = 32'h0;
        end
        test_reset;
        test_directed;
        test_req_held;
        test_reset_mid_write;
        test_random;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
